// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: triple-redundant register bank with a background scrubber.
// Every word is held in three copies. User reads return the bitwise majority vote.
// The scrubber walks the bank and rewrites any word whose copies disagree.
// Defining TMR_FAULT_INJECT_EN adds a fault-injection port set (inj_*).
module tmr_scrub_ctrl #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_W          = 16,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             scrub_en,
  output logic             scrub_busy,
  output logic             pass_done,
  output logic [CNT_W-1:0] corr_count,
  output logic             multi_err,
  input  logic             clr_status
`ifdef TMR_FAULT_INJECT_EN
  ,
  input  logic             inj_en,
  input  logic [1:0]       inj_copy,
  input  logic [AW-1:0]    inj_addr,
  input  logic [WIDTH-1:0] inj_mask
`endif
);

  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [IW-1:0] CNT_LAST = IW'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_WRITE} state_t;

  function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Storage is flops rather than block RAM: every copy needs an asynchronous clear.
  logic [WIDTH-1:0] mem_q  [3][DEPTH];
  logic [WIDTH-1:0] mem_wd [3][DEPTH];
  logic             mem_we [3][DEPTH];

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] cr_q [3];
  logic [WIDTH-1:0] cr_d [3];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] corr_q, corr_d;
  logic             multi_q, multi_d;

  logic             wb_en;
  logic             advance;
  logic             collide;
  logic [WIDTH-1:0] scrub_vote;
  logic [1:0]       n_diff;

  // A user write to the word under scrub invalidates the latched copies.
  assign collide    = wr_en && (wr_addr == addr_q);
  assign scrub_vote = maj(cr_q[0], cr_q[1], cr_q[2]);
  assign n_diff     = 2'(cr_q[0] != scrub_vote) + 2'(cr_q[1] != scrub_vote)
                    + 2'(cr_q[2] != scrub_vote);

  // Per-copy write selection: user write beats write-back, which beats injection.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_we[c][w] = 1'b0;
        mem_wd[c][w] = mem_q[c][w];
`ifdef TMR_FAULT_INJECT_EN
        if (inj_en && (inj_copy == 2'(c)) && (inj_addr == AW'(w))) begin
          mem_we[c][w] = 1'b1;
          mem_wd[c][w] = mem_q[c][w] ^ inj_mask;
        end
`endif
        if (wb_en && (addr_q == AW'(w))) begin
          mem_we[c][w] = 1'b1;
          mem_wd[c][w] = scrub_vote;
        end
        if (wr_en && (wr_addr == AW'(w))) begin
          mem_we[c][w] = 1'b1;
          mem_wd[c][w] = wr_data;
        end
      end
    end
  end

  // Triplicated storage array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++)
        for (int w = 0; w < DEPTH; w++)
          mem_q[c][w] <= '0;
    end else begin
      for (int c = 0; c < 3; c++)
        for (int w = 0; w < DEPTH; w++)
          if (mem_we[c][w]) mem_q[c][w] <= mem_wd[c][w];
    end
  end

  // Scrub FSM next state, status counters and write-back request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cr_d      = cr_q;
    corr_d    = corr_q;
    multi_d   = multi_q;
    wb_en     = 1'b0;
    advance   = 1'b0;
    pass_d    = 1'b0;
    rd_data_d = maj(mem_q[0][rd_addr], mem_q[1][rd_addr], mem_q[2][rd_addr]);
    case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!scrub_en)              state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_READ;
        else                        cnt_d   = cnt_q + IW'(1);
      end
      S_READ: begin
        if (collide) begin
          advance = 1'b1;
        end else begin
          for (int c = 0; c < 3; c++) cr_d[c] = mem_q[c][addr_q];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (collide) begin
          advance = 1'b1;
        end else begin
          if (n_diff >= 2'd2) multi_d = 1'b1;
          if (n_diff != 2'd0) state_d = S_WRITE;
          else                advance = 1'b1;
        end
      end
      S_WRITE: begin
        if (!collide) begin
          wb_en = 1'b1;
          if (corr_q != '1) corr_d = corr_q + CNT_W'(1);
        end
        advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A finished (or aborted) step moves on; scrub_en low parks the FSM.
    if (advance) begin
      addr_d  = addr_q + AW'(1);
      pass_d  = &addr_q;
      cnt_d   = '0;
      state_d = scrub_en ? S_WAIT : S_IDLE;
    end
    if (clr_status) begin
      corr_d  = '0;
      multi_d = 1'b0;
    end
    busy_d = (state_d == S_READ) || (state_d == S_CHECK) || (state_d == S_WRITE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      for (int c = 0; c < 3; c++) cr_q[c] <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      corr_q    <= '0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      for (int c = 0; c < 3; c++) cr_q[c] <= cr_d[c];
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      corr_q    <= corr_d;
      multi_q   <= multi_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign scrub_busy = busy_q;
  assign pass_done  = pass_q;
  assign corr_count = corr_q;
  assign multi_err  = multi_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Testbench for tmr_scrub_ctrl: directed vector table, hand-written scrub
// sequences, and randomized rounds checked against a word-level model.
// Faults are planted by depositing into the copy arrays of the design.
module tb_tmr_scrub_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int SI    = 4;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [AW-1:0]    rd_addr = '0;
  logic             scrub_en = 1'b0;
  logic             clr_status = 1'b0;

  logic [WIDTH-1:0] rd_data, rd_data2;
  logic             busy, busy2, pass_done, pass2, multi, multi2;
  logic [15:0]      corr;
  logic [1:0]       corr2;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mdl [3][DEPTH];
  bit               dirty [DEPTH];
  logic [WIDTH-1:0] exp_rd;
  bit               rd_pend = 0;

  always #5 clk = ~clk;

  tmr_scrub_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .scrub_en(scrub_en), .scrub_busy(busy),
    .pass_done(pass_done), .corr_count(corr), .multi_err(multi), .clr_status(clr_status)
`ifdef TMR_FAULT_INJECT_EN
    , .inj_en(1'b0), .inj_copy(2'd0), .inj_addr(4'd0), .inj_mask(8'd0)
`endif
  );

  // Same stimulus, narrow counter to exercise saturation.
  tmr_scrub_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data2), .scrub_en(scrub_en), .scrub_busy(busy2),
    .pass_done(pass2), .corr_count(corr2), .multi_err(multi2), .clr_status(clr_status)
`ifdef TMR_FAULT_INJECT_EN
    , .inj_en(1'b0), .inj_copy(2'd0), .inj_addr(4'd0), .inj_mask(8'd0)
`endif
  );

  typedef struct {
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vt [7];

  // Bitwise 2-of-3 vote, computed bit by bit as a population count.
  function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic corrupt(input int c, input int a, input logic [WIDTH-1:0] m);
    logic [1:0]    ci;
    logic [AW-1:0] ai;
    ci = c[1:0];
    ai = a[AW-1:0];
    dut.mem_q[ci][ai]  = dut.mem_q[ci][ai] ^ m;
    dut2.mem_q[ci][ai] = dut2.mem_q[ci][ai] ^ m;
    mdl[ci][ai]        = mdl[ci][ai] ^ m;
  endtask

  task automatic user_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic wait_pass(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (pass_done !== 1'b1 && n < 300);
    checks++;
    if (pass_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: pass_done not seen within %0d cycles", name, n);
    end
  endtask

  task automatic check_word(input string name, input int a, input logic [WIDTH-1:0] v);
    int bad;
    bad = 0;
    for (int c = 0; c < 3; c++)
      if (dut.mem_q[c][a[AW-1:0]] !== v) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // One randomized cycle: check the pending read, maybe corrupt, read, maybe write.
  task automatic rand_cycle(input bit allow_corrupt);
    int a;
    if (rd_pend) check("rand_rd", 32'(rd_data), 32'(exp_rd));
    if (allow_corrupt && $urandom_range(3) == 0)
      corrupt(int'($urandom_range(2)), int'($urandom_range(DEPTH-1)), 8'($urandom_range(255, 1)));
    rd_addr = 4'($urandom_range(DEPTH-1));
    exp_rd  = vote(mdl[0][rd_addr], mdl[1][rd_addr], mdl[2][rd_addr]);
    rd_pend = 1;
    wr_en   = 1'b0;
    if ($urandom_range(1) == 1) begin
      a = int'($urandom_range(DEPTH-1));
      if (!dirty[a]) begin
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = 8'($urandom);
        for (int c = 0; c < 3; c++) mdl[c][a] = wr_data;
      end
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n, prev, nbad, bad;
    bit em;
    logic [WIDTH-1:0] v;

    for (int c = 0; c < 3; c++)
      for (int w = 0; w < DEPTH; w++) mdl[c][w] = '0;
    for (int w = 0; w < DEPTH; w++) dirty[w] = 0;

    vt[0] = '{1'b1, 4'd3, 8'hA5, 4'd3, 8'h00};
    vt[1] = '{1'b0, 4'd0, 8'h00, 4'd3, 8'hA5};
    vt[2] = '{1'b1, 4'd5, 8'h3C, 4'd3, 8'hA5};
    vt[3] = '{1'b1, 4'd2, 8'hFF, 4'd5, 8'h3C};
    vt[4] = '{1'b1, 4'd3, 8'h5A, 4'd2, 8'hFF};
    vt[5] = '{1'b0, 4'd0, 8'h00, 4'd3, 8'h5A};
    vt[6] = '{1'b0, 4'd0, 8'h00, 4'd0, 8'h00};

    // Reset state.
    @(negedge clk);
    tick();
    check("reset_outputs", 32'({rd_data, busy, pass_done, corr, multi}), 32'd0);
    rst = 1'b1;
    tick();
    check("post_reset_outputs", 32'({rd_data, busy, pass_done, corr, multi}), 32'd0);

    // Vector table: writes and registered voted reads.
    for (int i = 0; i < 7; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; rd_addr = vt[i].ra;
      tick();
      check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vt[i].exp));
    end
    wr_en = 1'b0;
    check("vec_corr", 32'(corr), 32'd0);

    // Single-copy upset corrected by one pass.
    corrupt(1, 5, 8'h01);
    rd_addr = 4'd5;
    tick();
    check("t2_voted_rd", 32'(rd_data), 32'h3C);
    scrub_en = 1'b1;
    wait_pass("t2_pass");
    scrub_en = 1'b0;
    check("t2_corr", 32'(corr), 32'd1);
    check("t2_multi", 32'(multi), 32'd0);
    check("t2_copy1", 32'(dut.mem_q[1][5]), 32'h3C);
    tick(); tick();

    // Two copies upset in one word: multi_err, then clear.
    pulse_clr();
    corrupt(0, 2, 8'h0F);
    corrupt(2, 2, 8'hF0);
    rd_addr = 4'd2;
    tick();
    check("t3_voted_rd", 32'(rd_data), 32'hFF);
    scrub_en = 1'b1;
    wait_pass("t3_pass");
    scrub_en = 1'b0;
    check("t3_multi", 32'(multi), 32'd1);
    check("t3_corr", 32'(corr), 32'd1);
    check_word("t3_copies", 2, 8'hFF);
    tick(); tick();
    pulse_clr();
    check("t3_clr", 32'({corr, multi}), 32'd0);

    // User write to the scrubbed word during CHECK aborts the step.
    corrupt(2, 7, 8'h40);
    scrub_en = 1'b1;
    rises = 0; n = 0; prev = 0;
    while (rises < 8 && n < 300) begin
      tick();
      n++;
      if (busy && prev == 0) rises++;
      prev = int'(busy);
    end
    check("t4_reach_addr7", 32'(rises), 32'd8);
    tick();
    user_write(4'd7, 8'h11);
    tick(); tick(); tick();
    check("t4_corr", 32'(corr), 32'd0);
    check("t4_multi", 32'(multi), 32'd0);
    check_word("t4_copies", 7, 8'h11);

    // Fault-free pass period.
    wait_pass("t5_first");
    n = 0;
    do begin
      tick();
      n++;
    end while (pass_done !== 1'b1 && n < 200);
    check("t5_period", 32'(n), 32'(DEPTH * (SI + 2)));
    check("t5_corr", 32'(corr), 32'd0);
    scrub_en = 1'b0;
    tick(); tick();

    // Saturation of a 2-bit counter, then reset in the middle of a write-back.
    pulse_clr();
    corrupt(1, 1, 8'h80);
    corrupt(1, 3, 8'h80);
    corrupt(1, 5, 8'h80);
    corrupt(1, 9, 8'h80);
    scrub_en = 1'b1;
    wait_pass("t6_pass");
    check("t6_corr_wide", 32'(corr), 32'd4);
    check("t6_corr_sat", 32'(corr2), 32'd3);
    for (int w = 0; w < DEPTH; w++) corrupt(0, w, 8'h01);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick(); tick();
    check("t6_busy_mid_write", 32'(busy), 32'd1);
    rst = 1'b0;
    scrub_en = 1'b0;
    #1;
    check("t6_rst_outputs", 32'({rd_data, busy, pass_done, corr, multi}), 32'd0);
    check("t6_rst_outputs2", 32'({rd_data2, busy2, pass2, corr2, multi2}), 32'd0);
    bad = 0;
    for (int c = 0; c < 3; c++)
      for (int w = 0; w < DEPTH; w++)
        if (dut.mem_q[c][w] !== '0 || dut2.mem_q[c][w] !== '0) bad++;
    check("t6_rst_copies", 32'(bad), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++)
      for (int w = 0; w < DEPTH; w++) mdl[c][w] = '0;
    tick();

    // Randomized rounds: upsets with scrub off, then a scrubbing window.
    for (int r = 0; r < 4; r++) begin
      pulse_clr();
      for (int w = 0; w < DEPTH; w++) dirty[w] = 0;
      rd_pend = 0;
      for (int cyc = 0; cyc < 40; cyc++) rand_cycle(1'b1);
      wr_en = 1'b0;
      nbad = 0;
      em = 0;
      for (int w = 0; w < DEPTH; w++) begin
        int nd;
        v  = vote(mdl[0][w], mdl[1][w], mdl[2][w]);
        nd = int'(mdl[0][w] != v) + int'(mdl[1][w] != v) + int'(mdl[2][w] != v);
        dirty[w] = (nd != 0);
        if (nd != 0) nbad++;
        if (nd >= 2) em = 1;
      end
      scrub_en = 1'b1;
      for (int cyc = 0; cyc < 130; cyc++) rand_cycle(1'b0);
      wr_en = 1'b0;
      scrub_en = 1'b0;
      check("rand_rd", 32'(rd_data), 32'(exp_rd));
      rd_pend = 0;
      tick(); tick(); tick(); tick();
      for (int w = 0; w < DEPTH; w++) begin
        v = vote(mdl[0][w], mdl[1][w], mdl[2][w]);
        for (int c = 0; c < 3; c++) mdl[c][w] = v;
      end
      check($sformatf("rand%0d_corr", r), 32'(corr), 32'(nbad));
      check($sformatf("rand%0d_corr_sat", r), 32'(corr2), 32'((nbad > 3) ? 3 : nbad));
      check($sformatf("rand%0d_multi", r), 32'(multi), 32'(em));
      bad = 0;
      for (int c = 0; c < 3; c++)
        for (int w = 0; w < DEPTH; w++)
          if (dut.mem_q[c][w] !== mdl[c][w] || dut2.mem_q[c][w] !== mdl[c][w]) bad++;
      check($sformatf("rand%0d_copies", r), 32'(bad), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
